bulk_rx_decoder: RTL and testbench

BULK_RX_DECODER -- requirements
Module: bulk_rx_decoder

---
 rtl/bulk_rx_decoder_if.sv | 17 +
 rtl/bulk_rx_decoder.sv | 150 +++++++++++++++
 tb/tb_bulk_rx_decoder.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bulk_rx_decoder_if.sv
// w_busif: single-beat write bus carrying a data word and a register address,
// with valid/ready backpressure from the register controller.
`timescale 1ns/1ps
interface w_busif #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 256
);
  localparam int ADDR_WIDTH = $clog2(RAM_DEPTH);

  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  valid;
  logic                  ready;

  modport master (output data, addr, valid, input ready);
  modport slave  (input data, addr, valid, output ready);
endinterface

// File: rtl/bulk_rx_decoder.sv
// bulk_rx_decoder: turns a SYNC/ADDR/D3..D0[/CSUM] byte stream into single
// register writes. Define BULK_RX_CHECKSUM_EN to add the trailing XOR checksum byte.
`timescale 1ns/1ps
module bulk_rx_decoder #(
  parameter int         DATA_WIDTH     = 32,
  parameter int         RAM_DEPTH      = 256,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  w_busif.master      bulk_rx,
  output logic [15:0] frame_count,
  output logic [15:0] err_count
);

  localparam int            AW       = $clog2(RAM_DEPTH);
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
`ifdef BULK_RX_CHECKSUM_EN
    S_CSUM,
`endif
    S_OUT
  } state_t;

  state_t                state_q;
  logic [1:0]            idx_q;
  logic [TW-1:0]         tmo_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [AW-1:0]         addr_q;
  logic [15:0]           frame_q;
  logic [15:0]           err_q;
`ifdef BULK_RX_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  logic accept;

  // Gating with rstn keeps the byte source stalled for the whole reset pulse,
  // not just from the first reset edge onward.
  assign in_ready = rstn && (state_q != S_OUT);
  assign accept   = in_valid && in_ready;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // NOTE: all state lives in one clocked block and is updated with <= so every
  // branch sees the pre-edge values; a blocking = here would chain updates.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      frame_q <= '0;
      err_q   <= '0;
`ifdef BULK_RX_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          tmo_q <= '0;
          if (accept && in_data == SYNC_BYTE) state_q <= S_ADDR;
        end

        // Frame stays presented until the consumer takes it; no timeout here.
        S_OUT: begin
          if (bulk_rx.ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            frame_q <= sat_inc(frame_q);
          end
        end

        default: begin
          if (accept) begin
            tmo_q <= '0;
            case (state_q)
              S_ADDR: begin
                addr_q  <= AW'(in_data);
                idx_q   <= 2'd0;
                state_q <= S_DATA;
`ifdef BULK_RX_CHECKSUM_EN
                csum_q  <= in_data;
`endif
              end
              S_DATA: begin
                case (idx_q)
                  2'd0:    data_q[31:24] <= in_data;
                  2'd1:    data_q[23:16] <= in_data;
                  2'd2:    data_q[15:8]  <= in_data;
                  default: data_q[7:0]   <= in_data;
                endcase
                idx_q <= idx_q + 2'd1;
`ifdef BULK_RX_CHECKSUM_EN
                csum_q <= csum_q ^ in_data;
                if (idx_q == 2'd3) state_q <= S_CSUM;
`else
                if (idx_q == 2'd3) begin
                  state_q <= S_OUT;
                  valid_q <= 1'b1;
                end
`endif
              end
`ifdef BULK_RX_CHECKSUM_EN
              S_CSUM: begin
                if (in_data == csum_q) begin
                  state_q <= S_OUT;
                  valid_q <= 1'b1;
                end else begin
                  state_q <= S_IDLE;
                  err_q   <= sat_inc(err_q);
                end
              end
`endif
              default: state_q <= S_IDLE;
            endcase
          end else if (tmo_q == TMO_LAST) begin
            // An accepted byte takes priority over an expiring timeout.
            state_q <= S_IDLE;
            tmo_q   <= '0;
            err_q   <= sat_inc(err_q);
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
      endcase
    end
  end

  assign bulk_rx.valid = valid_q;
  assign bulk_rx.data  = data_q;
  assign bulk_rx.addr  = addr_q;
  assign frame_count   = frame_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_bulk_rx_decoder.sv
// Scoreboard bench for bulk_rx_decoder: frames are built as byte lists, the
// expected write is queued at issue time and a monitor pops it on each handshake.
`timescale 1ns/1ps
module tb_bulk_rx_decoder;

  localparam int         T    = 1000;
  localparam logic [7:0] SYNC = 8'hA5;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  typedef enum {RDY_RANDOM, RDY_HOLD, RDY_ALWAYS} rdy_mode_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] frame_count;
  logic [15:0] err_count;

  w_busif #(.DATA_WIDTH(32), .RAM_DEPTH(256)) bus ();

  bulk_rx_decoder #(
    .DATA_WIDTH(32), .RAM_DEPTH(256), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bulk_rx(bus), .frame_count(frame_count),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_errors = 0;
  exp_t      exp_q[$];
  int        frame_exp = 0;
  int        err_exp = 0;
  rdy_mode_t rdy_mode = RDY_ALWAYS;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer-side ready, changed well clear of both clock edges.
  initial begin
    bus.ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        RDY_HOLD:   bus.ready = 1'b0;
        RDY_ALWAYS: bus.ready = 1'b1;
        default:    bus.ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: stability while stalled, in_ready low in OUT, scoreboard pop on handshake.
  initial begin
    bit          held = 1'b0;
    logic [7:0]  pa = '0;
    logic [31:0] pd = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        held = 1'b0;
      end else if (bus.valid) begin
        check("in_ready while valid", in_ready, 0);
        if (held) begin
          check("addr stable", bus.addr, pa);
          check("data stable", bus.data, pd);
        end
        if (bus.ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected valid", bus.valid, 0);
          end else begin
            e = exp_q.pop_front();
            check("addr", bus.addr, e.addr);
            check("data", bus.data, e.data);
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          pa   = bus.addr;
          pd   = bus.data;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("in_ready wait", in_ready, 1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Builds the frame bytes, optionally stalls after byte stall_idx, and records the outcome.
  task automatic send_frame(input logic [7:0] addr, input logic [31:0] data, input bit bad_in,
                            input int max_gap, input int stall_idx, input int stall_len);
    logic [7:0] fb[$];
    bit         bad = bad_in;
    exp_t       e;
    fb.push_back(SYNC);
    fb.push_back(addr);
    for (int k = 3; k >= 0; k--) fb.push_back(data[8*k +: 8]);
`ifdef BULK_RX_CHECKSUM_EN
    begin
      logic [7:0] x = 8'h00;
      for (int k = 1; k < 6; k++) x ^= fb[k];
      if (bad) x ^= 8'($urandom_range(1, 255));
      fb.push_back(x);
    end
`else
    bad = 1'b0;
`endif
    if (!bad) begin
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
      frame_exp++;
    end
    for (int i = 0; i < fb.size(); i++) begin
      send_byte(fb[i]);
      if (i == stall_idx) idle(stall_len);
      else if (i < fb.size() - 1 && max_gap > 0) idle($urandom_range(0, max_gap));
    end
    check("valid one cycle after last byte", bus.valid, !bad);
    if (bad) begin
      err_exp++;
      check("err_count after bad csum", err_count, err_exp);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) check("drain timeout, frames left", exp_q.size(), 0);
    @(posedge clk);
    #1;
    check("frame_count", frame_count, frame_exp);
    check("err_count", err_count, err_exp);
  endtask

  task automatic check_reset_outputs();
    check("reset in_ready", in_ready, 0);
    check("reset valid", bus.valid, 0);
    check("reset data", bus.data, 0);
    check("reset addr", bus.addr, 0);
    check("reset frame_count", frame_count, 0);
    check("reset err_count", err_count, 0);
  endtask

  initial begin
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rstn = 1'b1;
    #1;
    check("in_ready after reset release", in_ready, 1);

    // Basic frame with ready always high.
    send_frame(8'h7F, 32'h12345678, 1'b0, 0, -1, 0);
    drain();

`ifdef BULK_RX_CHECKSUM_EN
    // Zero checksum byte must be rejected, then a good frame still decodes.
    send_byte(SYNC); send_byte(8'h7F); send_byte(8'h12);
    send_byte(8'h34); send_byte(8'h56); send_byte(8'h78); send_byte(8'h00);
    check("no valid on bad csum", bus.valid, 0);
    err_exp++;
    check("err_count csum 00", err_count, err_exp);
    send_frame(8'h7F, 32'h12345678, 1'b0, 0, -1, 0);
    drain();
`endif

    // Leading garbage ignored in IDLE.
    send_byte(8'h00);
    send_byte(8'h3C);
    send_frame(8'hFF, 32'h12345678, 1'b0, 0, -1, 0);
    drain();

    // Sync value inside a frame is payload.
    send_frame(SYNC, 32'hA5A5A5A5, 1'b0, 1, -1, 0);
    drain();

    // Timeout mid-frame after exactly T idle cycles.
    send_byte(SYNC); send_byte(8'h10); send_byte(8'hAA);
    idle(T);
    err_exp++;
    check("err_count after timeout", err_count, err_exp);
    check("no valid after timeout", bus.valid, 0);
    send_frame(8'h22, 32'hDEADBEEF, 1'b0, 0, -1, 0);
    drain();

    // T-1 idle cycles: the next byte lands on the expiring cycle and wins.
    send_frame(8'h33, 32'hCAFEF00D, 1'b0, 0, 3, T - 1);
    drain();

    // Backpressure: frame held for 50 cycles.
    rdy_mode = RDY_HOLD;
    idle(2);
    send_frame(8'h44, 32'h0BADC0DE, 1'b0, 0, -1, 0);
    idle(50);
    check("valid held under backpressure", bus.valid, 1);
    check("addr held", bus.addr, 8'h44);
    check("data held", bus.data, 32'h0BADC0DE);
    check("frame_count unchanged while held", frame_count, frame_exp - 1);
    rdy_mode = RDY_ALWAYS;
    drain();

    // Reset mid-frame discards it without counting an error.
    send_byte(SYNC); send_byte(8'h7F); send_byte(8'h12);
    rstn = 1'b0;
    #1;
    check("in_ready low during reset", in_ready, 0);
    @(posedge clk);
    #1;
    check_reset_outputs();
    rstn = 1'b1;
    frame_exp = 0;
    err_exp   = 0;
    #1;
    check("in_ready after mid-frame reset", in_ready, 1);
    send_frame(8'h7F, 32'h12345678, 1'b0, 0, -1, 0);
    drain();

    // Randomized traffic: junk, gaps, bad checksums, random backpressure.
    rdy_mode = RDY_RANDOM;
    for (int f = 0; f < 40; f++) begin
      int njunk = $urandom_range(0, 2);
      for (int j = 0; j < njunk; j++) begin
        logic [7:0] jb = 8'($urandom_range(0, 255));
        if (jb == SYNC) jb = 8'h00;
        send_byte(jb);
      end
      send_frame(8'($urandom_range(0, 255)), $urandom(), ($urandom_range(0, 4) == 0),
                 3, -1, 0);
    end
    rdy_mode = RDY_ALWAYS;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
